// File: rtl/fully_registered_handshake_pkg.sv
// Shared defaults and state encoding for the fully registered valid/ready slice.
package fully_registered_handshake_pkg;

  localparam int unsigned WIDTH_DEF = 9;
  localparam int unsigned DEPTH_DEF = 256;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  // Number of words held by the slice in a given state.
  function automatic logic [1:0] occupancy(input state_e st);
    case (st)
      EMPTY:   occupancy = 2'd0;
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/fully_registered_handshake_if.sv
// Source/destination handshake bundle; slave = the slice, master = the environment.
interface fully_registered_handshake_if
  import fully_registered_handshake_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) ();

  logic             idle;
  logic             src_vaild;
  logic [WIDTH-1:0] src_data_in;
  logic             src_ready;
  logic             dst_ready;
  logic             dst_vaild;
  logic [WIDTH-1:0] dst_data_out;

  modport slave (
    input  idle,
    input  src_vaild,
    input  src_data_in,
    output src_ready,
    input  dst_ready,
    output dst_vaild,
    output dst_data_out
  );

  modport master (
    output idle,
    output src_vaild,
    output src_data_in,
    input  src_ready,
    output dst_ready,
    input  dst_vaild,
    input  dst_data_out
  );

endinterface

// File: rtl/fully_registered_handshake.sv
// Two-entry skid buffer: every output driven straight from a flop, one word per clock.
module fully_registered_handshake
  import fully_registered_handshake_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          s_rst,
  fully_registered_handshake_if.slave   bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             src_ready_q, src_ready_d;
  logic             dst_vaild_q, dst_vaild_d;
  logic             in_fire, out_fire;

  assign in_fire  = bus.src_vaild & src_ready_q;
  assign out_fire = dst_vaild_q & bus.dst_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = ONE;
          main_d  = bus.src_data_in;
        end
      end
      ONE: begin
        case ({in_fire, out_fire})
          2'b10: begin
            state_d = FULL;
            skid_d  = bus.src_data_in;
          end
          2'b11: main_d = bus.src_data_in;
          2'b01: state_d = EMPTY;
          default: ;
        endcase
      end
      FULL: begin
        // src_ready is low here, so only the output side can move.
        if (out_fire) begin
          state_d = ONE;
          main_d  = skid_q;
          skid_d  = '0;
        end
      end
      default: state_d = EMPTY;
    endcase
    dst_vaild_d = (state_d != EMPTY);
    src_ready_d = (state_d != FULL) && !bus.idle;
  end

  always_ff @(posedge clk or posedge s_rst) begin
    if (s_rst) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      src_ready_q <= 1'b0;
      dst_vaild_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      src_ready_q <= src_ready_d;
      dst_vaild_q <= dst_vaild_d;
    end
  end

  assign bus.src_ready    = src_ready_q;
  assign bus.dst_vaild    = dst_vaild_q;
  assign bus.dst_data_out = main_q;

  a_dst_hold: assert property (@(posedge clk) disable iff (s_rst)
    (dst_vaild_q && !bus.dst_ready) |=> (dst_vaild_q && $stable(main_q)));

  a_ready_room: assert property (@(posedge clk) disable iff (s_rst)
    src_ready_q |-> (occupancy(state_q) < 2'd2));

endmodule

// File: tb/tb_fully_registered_handshake.sv
// Randomized scoreboard bench: input fires push into a FIFO model, a monitor checks the output side.
module tb_fully_registered_handshake;
  import fully_registered_handshake_pkg::*;

  localparam int unsigned WIDTH = WIDTH_DEF;
  localparam int unsigned DEPTH = DEPTH_DEF;

  logic clk   = 1'b0;
  logic s_rst = 1'b1;
  always #5 clk = ~clk;

  fully_registered_handshake_if #(.WIDTH(WIDTH)) bus ();

  fully_registered_handshake #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .s_rst (s_rst),
    .bus   (bus.slave)
  );

  int unsigned      checks = 0;
  int unsigned      fails  = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic             exp_rdy = 1'b0;
  logic [WIDTH-1:0] src_cur;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, req);
    end
  endtask

  // Monitor: the slice is a 2-word FIFO; outputs observed on the falling edge.
  always @(negedge clk) begin
    logic pop;
    if (s_rst) begin
      exp_q.delete();
      exp_rdy = 1'b0;
    end else begin
      check("dst_vaild", bus.dst_vaild, (exp_q.size() != 0));
      check("src_ready", bus.src_ready, exp_rdy);
      if (bus.dst_vaild && exp_q.size() != 0)
        check("dst_data_out", bus.dst_data_out, exp_q[0]);
      pop = bus.dst_vaild && bus.dst_ready && (exp_q.size() != 0);
      if (pop) void'(exp_q.pop_front());
      if (bus.src_vaild && bus.src_ready) exp_q.push_back(bus.src_data_in);
      exp_rdy = (exp_q.size() < 2) && !bus.idle;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Source: holds a word until it fires. gap>0 toggles valid in gap-cycle bursts;
  // idle_mode toggles idle with random run lengths.
  task automatic run_src(input int unsigned n, input int unsigned vprob, input int unsigned rprob,
                         input int unsigned gap, input bit idle_mode, input bit rnd_data);
    int unsigned sent = 0;
    int unsigned cyc = 0;
    int unsigned idle_left = 0;
    while (sent < n && cyc < 20000) begin
      if (gap > 0) bus.src_vaild = ((cyc / gap) % 2) == 0;
      else         bus.src_vaild = ($urandom_range(99) < vprob);
      bus.src_data_in = src_cur;
      bus.dst_ready   = ($urandom_range(99) < rprob);
      if (idle_mode) begin
        if (idle_left == 0) begin
          bus.idle  = ~bus.idle;
          idle_left = $urandom_range(30, 2);
        end
        idle_left--;
      end else begin
        bus.idle = 1'b0;
      end
      @(negedge clk);
      if (bus.src_vaild && bus.src_ready) begin
        sent++;
        src_cur = rnd_data ? WIDTH'($urandom) : src_cur + 1'b1;
      end
      next_cycle();
      cyc++;
    end
    check("src_budget", WIDTH'(sent), WIDTH'(n));
  endtask

  task automatic drain();
    int unsigned n = 0;
    bus.src_vaild = 1'b0;
    bus.dst_ready = 1'b1;
    bus.idle      = 1'b0;
    while (exp_q.size() != 0 && n < 50) begin
      next_cycle();
      n++;
    end
    next_cycle();
    check("drain_empty", WIDTH'(exp_q.size()), '0);
  endtask

  initial begin
    int unsigned n;
    bus.idle        = 1'b0;
    bus.src_vaild   = 1'b0;
    bus.src_data_in = '0;
    bus.dst_ready   = 1'b0;
    src_cur         = '0;

    // Reset state
    #100;
    check("rst_src_ready", bus.src_ready, 1'b0);
    check("rst_dst_vaild", bus.dst_vaild, 1'b0);
    check("rst_dst_data", bus.dst_data_out, '0);
    next_cycle();
    s_rst = 1'b0;
    next_cycle();
    check("ready_after_release", bus.src_ready, 1'b1);

    // Streaming 0..9, full throughput
    run_src(10, 100, 100, 0, 1'b0, 1'b0);
    drain();

    // Back-pressure with 5, 6
    bus.dst_ready   = 1'b0;
    bus.src_vaild   = 1'b1;
    bus.src_data_in = 9'd5;
    next_cycle();
    bus.src_data_in = 9'd6;
    next_cycle();
    bus.src_vaild = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_src_ready", bus.src_ready, 1'b0);
      check("bp_hold", bus.dst_data_out, 9'd5);
      next_cycle();
    end
    bus.dst_ready = 1'b1;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    check("bp_second", bus.dst_data_out, 9'd6);
    check("bp_ready_back", bus.src_ready, 1'b1);
    next_cycle();
    drain();

    // Source gaps, then idle toggling with a full DEPTH sequence, then random data
    src_cur = '0;
    run_src(40, 0, 70, 8, 1'b0, 1'b0);
    drain();
    src_cur = '0;
    run_src(DEPTH, 80, 60, 0, 1'b1, 1'b0);
    drain();
    run_src(400, 70, 50, 0, 1'b1, 1'b1);
    drain();

    // Reset while FULL
    bus.dst_ready   = 1'b0;
    bus.src_vaild   = 1'b1;
    bus.src_data_in = 9'h1a5;
    n = 0;
    while (exp_q.size() < 2 && n < 10) begin
      next_cycle();
      n++;
    end
    check("reach_full", WIDTH'(exp_q.size()), 9'd2);
    bus.src_vaild = 1'b0;
    #2;
    s_rst = 1'b1;
    #1;
    check("mid_rst_src_ready", bus.src_ready, 1'b0);
    check("mid_rst_dst_vaild", bus.dst_vaild, 1'b0);
    check("mid_rst_dst_data", bus.dst_data_out, '0);
    next_cycle();
    next_cycle();
    s_rst = 1'b0;
    next_cycle();
    src_cur = '0;
    run_src(30, 90, 80, 0, 1'b0, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
